// File: rtl/conversor_bin_bcd_if.sv
// Handshake bundle for the binary-to-decimal converter.
// Input side: in_valid/in_ready carry bin_in and mode_in (0 = 8421 BCD, 1 = Excess-3).
// Output side: out_valid/out_ready carry dec_out (digit k at [4k+3:4k]) and overflow.
interface conversor_bin_bcd_if #(
  parameter int N      = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0]          bin_in;
  logic                  mode_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   dec_out;
  logic                  overflow;

  // master = producer of words / consumer of results
  modport master (
    output in_valid, bin_in, mode_in, out_ready,
    input  in_ready, out_valid, dec_out, overflow
  );

  // slave = the converter itself
  modport slave (
    input  in_valid, bin_in, mode_in, out_ready,
    output in_ready, out_valid, dec_out, overflow
  );
endinterface

// File: rtl/conversor_bin_bcd.sv
// Sequential binary-to-decimal converter (double dabble, one bit per clock), BCD or Excess-3 digits.
// Latency: word accepted at edge E, result valid after edge E+N; one word per N+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only asserted in IDLE.
// Ports: clk, rst_n (async, active-low), io_bus (slave modport of conversor_bin_bcd_if).
module conversor_bin_bcd #(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conversor_bin_bcd_if.slave    io_bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          r_state;
  logic [N-1:0]    r_bin;
  logic            r_mode;
  logic [W-1:0]    r_digits;
  logic            r_ovf_acc;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_dec_out;
  logic            r_overflow;
  logic            r_out_valid;

  logic [W-1:0]    w_adj;
  logic [W-1:0]    w_next;
  logic [W-1:0]    w_enc;
  logic            w_carry;

  always_comb begin
    w_adj = r_digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_digits[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_digits[4*k +: 4] + 4'd3;
      end
    end
    // Top bit of the adjusted top digit leaves the accumulator: that is a
    // decimal carry beyond DIGITS digits, i.e. the value no longer fits.
    w_carry = w_adj[W-1];
    w_next  = {w_adj[W-2:0], r_bin[N-1]};
    w_enc   = w_next;
    if (r_mode) begin
      for (int k = 0; k < DIGITS; k++) begin
        w_enc[4*k +: 4] = w_next[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_mode      <= 1'b0;
      r_digits    <= '0;
      r_ovf_acc   <= 1'b0;
      r_cnt       <= '0;
      r_dec_out   <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.in_valid) begin
            r_bin     <= io_bus.bin_in;
            r_mode    <= io_bus.mode_in;
            r_digits  <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_digits  <= w_next;
          r_bin     <= r_bin << 1;
          r_ovf_acc <= r_ovf_acc | w_carry;
          r_cnt     <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_dec_out   <= w_enc;
            r_overflow  <= r_ovf_acc | w_carry;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.in_ready  = (r_state == IDLE);
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.dec_out   = r_dec_out;
  assign io_bus.overflow  = r_overflow;
endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Bench for conversor_bin_bcd: two instances (N=8 with 3 and 2 digits) share one stimulus stream.
// Reference results come from decimal arithmetic on the input value (div/mod by 10).
// Ports driven: clk, rst_n, and both interface instances from shared tb signals.
module tb_conversor_bin_bcd;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       mode_in = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] bin_in = 8'd0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  conversor_bin_bcd_if #(.N(8), .DIGITS(3)) bus3 ();
  conversor_bin_bcd_if #(.N(8), .DIGITS(2)) bus2 ();

  assign bus3.in_valid  = in_valid;
  assign bus3.bin_in    = bin_in;
  assign bus3.mode_in   = mode_in;
  assign bus3.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.bin_in    = bin_in;
  assign bus2.mode_in   = mode_in;
  assign bus2.out_ready = out_ready;

  conversor_bin_bcd #(.N(8), .DIGITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .io_bus(bus3));
  conversor_bin_bcd #(.N(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .io_bus(bus2));

  function automatic logic [31:0] ref_dec(int v, bit m, int nd);
    logic [31:0] r;
    int p;
    r = '0;
    p = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'((p % 10) + (m ? 3 : 0));
      p = p / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_ovf(int v, int nd);
    int lim;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    return (v >= lim) ? 32'd1 : 32'd0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, measure latency, compare, optional stall, release.
  task automatic xact(int v, bit m, int stall);
    int         lat;
    logic [11:0] h3;
    logic [7:0]  h2;
    logic        ho3, ho2;
    @(negedge clk);
    check("in_ready_idle", {30'd0, bus3.in_ready, bus2.in_ready}, 32'h3);
    in_valid = 1'b1;
    bin_in   = 8'(v);
    mode_in  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bin_in   = 8'($urandom);
    mode_in  = 1'($urandom);
    check("in_ready_busy", {30'd0, bus3.in_ready, bus2.in_ready}, 32'h0);
    lat = 0;
    while (!bus3.out_valid && lat < 40) begin
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    out_ready = 1'b0;
    check("latency", lat, 8);
    check("out_valid_d2", {31'd0, bus2.out_valid}, 32'd1);
    check("dec_d3", {20'd0, bus3.dec_out}, ref_dec(v, m, 3));
    check("ovf_d3", {31'd0, bus3.overflow}, ref_ovf(v, 3));
    check("dec_d2", {24'd0, bus2.dec_out}, ref_dec(v, m, 2));
    check("ovf_d2", {31'd0, bus2.overflow}, ref_ovf(v, 2));
    h3 = ref_dec(v, m, 3) & 32'hfff;
    h2 = ref_dec(v, m, 2) & 32'hff;
    ho3 = ref_ovf(v, 3) != 0;
    ho2 = ref_ovf(v, 2) != 0;
    repeat (stall) begin
      in_valid = 1'b1;
      bin_in   = 8'($urandom);
      @(posedge clk);
      #1;
      check("hold", {8'd0, bus3.out_valid, bus3.in_ready, bus3.dec_out, bus3.overflow,
                     bus2.dec_out, bus2.overflow},
                    {8'd0, 1'b1, 1'b0, h3, ho3, h2, ho2});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release", {28'd0, bus3.out_valid, bus2.out_valid, bus3.in_ready, bus2.in_ready}, 32'h3);
  endtask

  initial begin
    #2;
    check("rst_d3", {16'd0, bus3.out_valid, bus3.in_ready, bus3.dec_out, bus3.overflow, 1'b0},
                    {16'd0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0});
    check("rst_d2", {20'd0, bus2.out_valid, bus2.in_ready, bus2.dec_out, bus2.overflow, 1'b0},
                    {20'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    xact(255, 1'b0, 0);
    xact(255, 1'b1, 0);
    xact(0,   1'b1, 0);
    xact(200, 1'b0, 0);
    xact(99,  1'b0, 0);
    xact(123, 1'b1, 5);
    xact(42,  1'b0, 0);

    // Reset in the middle of a conversion
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = 8'd137;
    mode_in  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_d3", {16'd0, bus3.out_valid, bus3.in_ready, bus3.dec_out, bus3.overflow, 1'b0},
                       {16'd0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0});
    check("midrst_d2", {20'd0, bus2.out_valid, bus2.in_ready, bus2.dec_out, bus2.overflow, 1'b0},
                       {20'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
    repeat (10) begin
      @(posedge clk);
      #1;
      check("no_spurious", {30'd0, bus3.out_valid, bus2.out_valid}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    xact(137, 1'b0, 0);

    // Sweep every value in both modes with random result stalls
    for (int v = 0; v < 256; v++) begin
      for (int m = 0; m < 2; m++) begin
        xact(v, m[0], int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
